// File: rtl/digit_entry_if.sv
// digit_entry_if: button inputs and edited/converted outputs of the digit entry block.
//   btn_inc, btn_dec, btn_left, btn_right, btn_enter : raw asynchronous push buttons, active-high
//   digits      : four BCD digits, [3:0] thousands .. [15:12] units
//   cursor      : active-low digit select, 4'b1110 = thousands .. 4'b0111 = units
//   value       : binary value of the last committed digits (0..9999)
//   value_valid : one-cycle pulse when value updates
//   busy        : high while a conversion is in progress
// The master modport drives the buttons; the slave modport is the digit entry block.
interface digit_entry_if;
    logic        btn_inc;
    logic        btn_dec;
    logic        btn_left;
    logic        btn_right;
    logic        btn_enter;
    logic [15:0] digits;
    logic [3:0]  cursor;
    logic [13:0] value;
    logic        value_valid;
    logic        busy;

    modport master (
        output btn_inc, btn_dec, btn_left, btn_right, btn_enter,
        input  digits, cursor, value, value_valid, busy
    );

    modport slave (
        input  btn_inc, btn_dec, btn_left, btn_right, btn_enter,
        output digits, cursor, value, value_valid, busy
    );
endinterface

// File: rtl/digit_entry.sv
// digit_entry: four-digit BCD editor with debounced buttons and BCD-to-binary conversion.
//   clk : system clock, all state changes on its rising edge
//   rst : synchronous active-high reset
//   bus : digit_entry_if slave (buttons in; digits, cursor, value, value_valid, busy out)
// Each button is synchronized, debounced over DEBOUNCE_CYCLES and turned into a rising-edge
// event. In idle, inc/dec edit the cursor digit and left/right move the cursor; enter
// snapshots the digits and converts them to binary over four cycles.
module digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    digit_entry_if.slave bus
);
    localparam int NumBtn = 5;
    localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // Button bit positions, lowest index = highest priority
    localparam int BtnEnter = 0;
    localparam int BtnInc   = 1;
    localparam int BtnDec   = 2;
    localparam int BtnLeft  = 3;
    localparam int BtnRight = 4;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    logic [NumBtn-1:0]           raw;
    logic [NumBtn-1:0]           sync1_q, sync2_q;
    logic [NumBtn-1:0]           stable_q, stable_d, stable_prev_q;
    logic [NumBtn-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NumBtn-1:0]           evt;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  pos_q, pos_d;
    logic [15:0] digits_q, digits_d;
    logic [15:0] snap_q, snap_d;
    logic [13:0] acc_q, acc_d;
    logic [13:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic [3:0]  cur_digit, snap_digit;

    assign raw = {bus.btn_right, bus.btn_left, bus.btn_dec, bus.btn_inc, bus.btn_enter};

    // Debounce: a counter of consecutive mismatches; the stable value flips on the last one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < NumBtn; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign evt = stable_q & ~stable_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    // Nibble 0 is thousands, so the cursor position doubles as the nibble index.
    assign cur_digit  = digits_q[{pos_q, 2'b00} +: 4];
    assign snap_digit = snap_q[{step_q, 2'b00} +: 4];

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        pos_d    = pos_q;
        digits_d = digits_q;
        snap_d   = snap_q;
        acc_d    = acc_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (evt[BtnEnter]) begin
                    snap_d  = digits_q;
                    acc_d   = '0;
                    step_d  = 2'd0;
                    state_d = StConv;
                end else if (evt[BtnInc]) begin
                    digits_d[{pos_q, 2'b00} +: 4] = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
                end else if (evt[BtnDec]) begin
                    digits_d[{pos_q, 2'b00} +: 4] = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
                end else if (evt[BtnLeft]) begin
                    pos_d = pos_q - 2'd1;
                end else if (evt[BtnRight]) begin
                    pos_d = pos_q + 2'd1;
                end
            end
            StConv: begin
                acc_d  = acc_q * 14'd10 + {10'd0, snap_digit};
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    value_d = acc_d;
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            step_q   <= '0;
            pos_q    <= '0;
            digits_q <= '0;
            snap_q   <= '0;
            acc_q    <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            pos_q    <= pos_d;
            digits_q <= digits_d;
            snap_q   <= snap_d;
            acc_q    <= acc_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.cursor      = ~(4'b0001 << pos_q);
    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.busy        = (state_q != StIdle);
endmodule
